// File: rtl/div_pkg.sv
// div_pkg: shared widths, FSM state type and saturation limits for signed_divider.
package div_pkg;
  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W = 16;
  localparam int ITER = 16;
  localparam logic [DIVISOR_W-1:0] Q_POS_SAT = 16'h7FFF;
  localparam logic [DIVISOR_W-1:0] Q_NEG_SAT = 16'h8000;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift/subtract iteration on magnitudes.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem,
  input  logic                 bit_in,
  input  logic [DIVISOR_W:0]   dmag,
  output logic [DIVISOR_W-1:0] rem_next,
  output logic                 q_bit
);
  logic [DIVISOR_W:0] trial;
  assign trial = {rem, bit_in};
  assign q_bit = trial >= dmag;
  assign rem_next = DIVISOR_W'(q_bit ? trial - dmag : trial);
endmodule

// File: rtl/signed_divider.sv
// signed_divider: 32/16 signed restoring divider, fixed 17-cycle start-to-done latency.
// Optional divide-by-zero flag port dbz is built when DIV_ZERO_CHECK_EN is defined.
module signed_divider
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  done,
  output logic                  ovf
`ifdef DIV_ZERO_CHECK_EN
  ,
  output logic                  dbz
`endif
);
  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIVISOR_W-1:0] pr_q, pr_d, lo_q, lo_d, quotient_q, quotient_d, remainder_q, remainder_d;
  logic [DIVISOR_W:0] bmag_q, bmag_d;
  logic neg_q, neg_d, rneg_q, rneg_d, pre_q, pre_d, ovf_q, ovf_d;
  logic [DIVIDEND_W-1:0] a_mag;
  logic [DIVISOR_W:0] b_ext, b_mag;
  logic [DIVISOR_W-1:0] rem_nxt;
  logic q_bit, ovf_fix;
`ifdef DIV_ZERO_CHECK_EN
  logic dz_q, dz_d, dbz_q, dbz_d;
`endif
  // 17-bit divisor magnitude keeps |-32768| exact; dividend magnitude 2^31 fits unsigned 32.
  assign a_mag = dividend[DIVIDEND_W-1] ? ~dividend + 32'd1 : dividend;
  assign b_ext = {divisor[DIVISOR_W-1], divisor};
  assign b_mag = divisor[DIVISOR_W-1] ? -b_ext : b_ext;
  // Saturation limits double as the magnitude bounds a signed 16-bit quotient can take.
  assign ovf_fix = pre_q | (lo_q > (neg_q ? Q_NEG_SAT : Q_POS_SAT));
  div_step u_step (
    .rem      (pr_q),
    .bit_in   (lo_q[DIVISOR_W-1]),
    .dmag     (bmag_q),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pr_d = pr_q;
    lo_d = lo_q;
    bmag_d = bmag_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    pre_d = pre_q;
    quotient_d = quotient_q;
    remainder_d = remainder_q;
    ovf_d = ovf_q;
`ifdef DIV_ZERO_CHECK_EN
    dz_d = dz_q;
    dbz_d = dbz_q;
`endif
    unique case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        cnt_d = '0;
        pr_d = a_mag[DIVIDEND_W-1:DIVISOR_W];
        lo_d = a_mag[DIVISOR_W-1:0];
        bmag_d = b_mag;
        neg_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
        rneg_d = dividend[DIVIDEND_W-1];
        // A zero divisor always lands here too, so it saturates by dividend sign.
        pre_d = {1'b0, a_mag[DIVIDEND_W-1:DIVISOR_W]} >= b_mag;
`ifdef DIV_ZERO_CHECK_EN
        dz_d = divisor == '0;
`endif
      end
      CALC: begin
        pr_d = rem_nxt;
        lo_d = {lo_q[DIVISOR_W-2:0], q_bit};
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == LAST ? FIX : CALC;
      end
      FIX: begin
        quotient_d = ovf_fix ? (neg_q ? Q_NEG_SAT : Q_POS_SAT) : (neg_q ? -lo_q : lo_q);
        remainder_d = ovf_fix ? '0 : (rneg_q ? -pr_q : pr_q);
        ovf_d = ovf_fix;
`ifdef DIV_ZERO_CHECK_EN
        dbz_d = dz_q;
`endif
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pr_q <= '0;
      lo_q <= '0;
      bmag_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      pre_q <= 1'b0;
      quotient_q <= '0;
      remainder_q <= '0;
      ovf_q <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dz_q <= 1'b0;
      dbz_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pr_q <= pr_d;
      lo_q <= lo_d;
      bmag_q <= bmag_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      pre_q <= pre_d;
      quotient_q <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q <= ovf_d;
`ifdef DIV_ZERO_CHECK_EN
      dz_q <= dz_d;
      dbz_q <= dbz_d;
`endif
    end
  end
  assign done = state_q == DONE;
  assign quotient = quotient_q;
  assign remainder = remainder_q;
  assign ovf = ovf_q;
`ifdef DIV_ZERO_CHECK_EN
  assign dbz = dbz_q;
`endif
endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: table-driven scoreboard bench for signed_divider (DIV_ZERO_CHECK_EN aware).
module tb_signed_divider;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient, remainder;
  logic done, ovf;
`ifdef DIV_ZERO_CHECK_EN
  logic dbz;
`endif
  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic ov;
    logic dz;
  } vec_t;
  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic ov;
    logic dz;
    int cyc;
  } exp_t;
  exp_t sb[$];
  vec_t tab[$];
  int checks = 0, errors = 0, cyc = 0;
  signed_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .ovf       (ovf)
`ifdef DIV_ZERO_CHECK_EN
    ,
    .dbz       (dbz)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  function automatic vec_t model(logic [31:0] a, logic [15:0] b);
    vec_t v;
    longint sa, sbv, q, r;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    v.a = a;
    v.b = b;
    v.dz = b == 16'h0;
    if (sbv == 0) begin
      v.ov = 1'b1;
      v.q = sa < 0 ? 16'h8000 : 16'h7FFF;
      v.r = '0;
    end else begin
      q = sa / sbv;
      r = sa % sbv;
      v.ov = q > 32767 || q < -32768;
      v.q = v.ov ? (q < 0 ? 16'h8000 : 16'h7FFF) : q[15:0];
      v.r = v.ov ? 16'h0 : r[15:0];
    end
    return v;
  endfunction
  function automatic exp_t to_exp(vec_t v, int c);
    exp_t e;
    e.q = v.q;
    e.r = v.r;
    e.ov = v.ov;
    e.dz = v.dz;
    e.cyc = c;
    return e;
  endfunction
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("ovf", 32'(ovf), 32'(e.ov));
`ifdef DIV_ZERO_CHECK_EN
        chk("dbz", 32'(dbz), 32'(e.dz));
`endif
        chk("latency", cyc, e.cyc);
      end
    end
  end
  task automatic drain(int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask
  task automatic run(vec_t v);
    @(negedge clk);
    dividend = v.a;
    divisor = v.b;
    start = 1'b1;
    sb.push_back(to_exp(v, cyc + 18));
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = 16'($urandom);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(40);
    repeat (3) @(negedge clk);
    chk("hold_quotient", 32'(quotient), 32'(v.q));
    chk("hold_remainder", 32'(remainder), 32'(v.r));
    repeat (18) @(negedge clk);
  endtask
  initial begin
    tab.push_back('{32'd3510, 16'hFFB2, 16'hFFD3, 16'h0000, 1'b0, 1'b0});
    tab.push_back('{32'd1000, 16'hFFF9, 16'hFF72, 16'h0006, 1'b0, 1'b0});
    tab.push_back('{32'hFFFFFC18, 16'h0007, 16'hFF72, 16'hFFFA, 1'b0, 1'b0});
    tab.push_back('{32'h7FFFFFFF, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 1'b0});
    tab.push_back('{32'hFFFF8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0});
    tab.push_back('{32'hFFFFFFFB, 16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b1});
    tab.push_back('{32'd12345, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1'b1});
    tab.push_back('{32'd100, 16'h000A, 16'h000A, 16'h0000, 1'b0, 1'b0});
    tab.push_back('{32'h80000000, 16'h8000, 16'h7FFF, 16'h0000, 1'b1, 1'b0});
    tab.push_back('{32'h80000000, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0});
    tab.push_back('{32'h3FFF8000, 16'h8000, 16'h8001, 16'h0000, 1'b0, 1'b0});
    tab.push_back('{32'hC0000000, 16'h8000, 16'h7FFF, 16'h0000, 1'b1, 1'b0});
    tab.push_back('{32'h40000000, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0});
    tab.push_back('{32'h7FFF0000, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0});
    tab.push_back('{32'hFFFFFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0});
    tab.push_back('{32'h00000007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) begin
      logic [15:0] x, y;
      longint p;
      x = 16'($urandom);
      y = 16'($urandom);
      p = longint'($signed(x)) * longint'($signed(y)) + longint'($urandom_range(0, 40)) - 20;
      tab.push_back(model(p[31:0], (i % 2 == 1) ? y : 16'($urandom)));
    end
    repeat (2) @(negedge clk);
    chk("reset_quotient", 32'(quotient), 32'h0);
    chk("reset_remainder", 32'(remainder), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_ovf", 32'(ovf), 32'h0);
`ifdef DIV_ZERO_CHECK_EN
    chk("reset_dbz", 32'(dbz), 32'h0);
`endif
    rst = 1'b0;
    foreach (tab[i]) run(tab[i]);
    @(negedge clk);
    dividend = tab[0].a;
    divisor = tab[0].b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("abort_quotient", 32'(quotient), 32'h0);
    chk("abort_remainder", 32'(remainder), 32'h0);
    chk("abort_ovf", 32'(ovf), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    repeat (25) @(negedge clk);
    run(tab[7]);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dividend = tab[k].a;
      divisor = tab[k].b;
      sb.push_back(to_exp(tab[k], cyc + 18));
      @(negedge clk);
      dividend = $urandom;
      divisor = 16'($urandom);
      repeat (18) @(negedge clk);
    end
    start = 1'b0;
    drain(40);
    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
